rvv_lane_alu_seq: RTL and testbench

- Parametrised, self-sequencing successor to the single-slice vector ALU.
- Accepts one whole vector instruction (vs1/vs2 register images, scalar, vl, vsew) through a start/ready handshake.
- Walks elements 0..vl-1 itself, emitting one LANE_W-bit result slice per beat under valid/ready backpressure.
- Adds vl handling, vsra, VX/VI scalar broadcast, illegal-op reporting, output stalling and an optional v0 mask.
- Sits between the vector register file read port and its slice-granular write port.

---
 rtl/rvv_lane_alu_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 tb/tb_rvv_lane_alu_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_lane_alu_seq.sv
// Self-sequencing vector lane ALU: latches one vector instruction and emits LANE_W-bit result slices.
// Optional v0 element masking is compiled in with the RVV_ALU_MASK_EN macro.
module rvv_lane_alu_seq #(
    parameter int VLEN   = 128,
    parameter int LANE_W = 32,
    parameter int ELEN   = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              ready,
    input  logic [5:0]        opcode,
    input  logic [2:0]        op_type,
    input  logic [2:0]        vsew,
    input  logic [7:0]        vl,
    input  logic [VLEN-1:0]   vs1_in,
    input  logic [VLEN-1:0]   vs2_in,
    input  logic [63:0]       scalar,
`ifdef RVV_ALU_MASK_EN
    input  logic [VLEN-1:0]   v0_mask,
    input  logic              vm,
`endif
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [LANE_W-1:0] wr_data,
    output logic [9:0]        wr_off,
    output logic              done,
    output logic              illegal
);

    localparam int MAXE   = VLEN / 8;
    localparam int LW_LOG = $clog2(LANE_W);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_RSUB = 6'b000011;
    localparam logic [5:0] OP_MINU = 6'b000100;
    localparam logic [5:0] OP_MIN  = 6'b000101;
    localparam logic [5:0] OP_MAXU = 6'b000110;
    localparam logic [5:0] OP_MAX  = 6'b000111;
    localparam logic [5:0] OP_AND  = 6'b001001;
    localparam logic [5:0] OP_OR   = 6'b001010;
    localparam logic [5:0] OP_XOR  = 6'b001011;
    localparam logic [5:0] OP_SLL  = 6'b100101;
    localparam logic [5:0] OP_SRL  = 6'b101000;
    localparam logic [5:0] OP_SRA  = 6'b101001;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR} state_t;

    function automatic logic [63:0] zext_sew(input logic [63:0] x, input logic [1:0] sew);
        case (sew)
            2'd0:    zext_sew = {56'd0, x[7:0]};
            2'd1:    zext_sew = {48'd0, x[15:0]};
            2'd2:    zext_sew = {32'd0, x[31:0]};
            default: zext_sew = x;
        endcase
    endfunction

    function automatic logic [63:0] sext_sew(input logic [63:0] x, input logic [1:0] sew);
        case (sew)
            2'd0:    sext_sew = {{56{x[7]}}, x[7:0]};
            2'd1:    sext_sew = {{48{x[15]}}, x[15:0]};
            2'd2:    sext_sew = {{32{x[31]}}, x[31:0]};
            default: sext_sew = x;
        endcase
    endfunction

    function automatic logic [63:0] get_elem(input logic [VLEN-1:0] vec, input logic [7:0] e,
                                             input logic [1:0] sew);
        logic [VLEN-1:0] sh;
        sh = vec >> ({2'd0, e} << (3'd3 + {1'b0, sew}));
        get_elem = zext_sew(sh[63:0], sew);
    endfunction

    function automatic logic [LANE_W-1:0] slice_of(input logic [63:0] v, input logic [3:0] s);
        logic [63:0] t;
        t = v >> (7'(s) << LW_LOG);
        slice_of = t[LANE_W-1:0];
    endfunction

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_RSUB, OP_MINU, OP_MIN, OP_MAXU, OP_MAX,
            OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA: op_supported = 1'b1;
            default: op_supported = 1'b0;
        endcase
    endfunction

    function automatic logic is_sub(input logic [5:0] op);
        is_sub = (op == OP_SUB) || (op == OP_RSUB);
    endfunction

    // Returns {carry_out, slice}; add/sub ripple through the carry flop, all else is whole-element.
    function automatic logic [LANE_W:0] calc_slice(input logic [5:0] op, input logic [63:0] a,
                                                   input logic [63:0] b, input logic [1:0] sew,
                                                   input logic [3:0] s, input logic cin);
        logic [63:0]       res;
        logic [5:0]        sh;
        logic [LANE_W-1:0] x;
        logic [LANE_W-1:0] y;
        logic [LANE_W:0]   sum;
        logic              use_add;
        res     = 64'd0;
        x       = slice_of(a, s);
        y       = slice_of(b, s);
        use_add = 1'b1;
        case (sew)
            2'd0:    sh = {3'd0, b[2:0]};
            2'd1:    sh = {2'd0, b[3:0]};
            2'd2:    sh = {1'b0, b[4:0]};
            default: sh = b[5:0];
        endcase
        case (op)
            OP_ADD:  y = slice_of(b, s);
            OP_SUB:  y = ~slice_of(b, s);
            OP_RSUB: begin x = slice_of(b, s); y = ~slice_of(a, s); end
            OP_MINU: begin use_add = 1'b0; res = (a < b) ? a : b; end
            OP_MAXU: begin use_add = 1'b0; res = (a < b) ? b : a; end
            OP_MIN:  begin
                use_add = 1'b0;
                res = ($signed(sext_sew(a, sew)) < $signed(sext_sew(b, sew))) ? a : b;
            end
            OP_MAX:  begin
                use_add = 1'b0;
                res = ($signed(sext_sew(a, sew)) < $signed(sext_sew(b, sew))) ? b : a;
            end
            OP_AND:  begin use_add = 1'b0; res = a & b; end
            OP_OR:   begin use_add = 1'b0; res = a | b; end
            OP_XOR:  begin use_add = 1'b0; res = a ^ b; end
            OP_SLL:  begin use_add = 1'b0; res = zext_sew(a << sh, sew); end
            OP_SRL:  begin use_add = 1'b0; res = a >> sh; end
            OP_SRA:  begin
                use_add = 1'b0;
                res = zext_sew(64'($signed(sext_sew(a, sew)) >>> sh), sew);
            end
            default: begin use_add = 1'b0; res = 64'd0; end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{LANE_W{1'b0}}, cin};
        if (use_add) begin
            calc_slice = {sum[LANE_W], slice_of(zext_sew(64'(sum[LANE_W-1:0]), sew), 4'd0)};
        end else begin
            calc_slice = {1'b0, slice_of(res, s)};
        end
    endfunction

    state_t            state_q, state_d;
    logic              ready_q, ready_d, wr_valid_q, wr_valid_d, done_q, done_d;
    logic              illegal_q, illegal_d, carry_q, carry_d;
    logic [LANE_W-1:0] wr_data_q, wr_data_d;
    logic [9:0]        wr_off_q, wr_off_d;
    logic [7:0]        elem_q, elem_d, vl_q, vl_d;
    logic [3:0]        slice_q, slice_d;
    logic [5:0]        op_q, op_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        sew_q, sew_d;
    logic [VLEN-1:0]   vs1_q, vs1_d, vs2_q, vs2_d;
    logic [63:0]       scalar_q, scalar_d;
    logic [MAXE-1:0]   act_q, act_d;

    logic [7:0]        vlmax_in_s, src_vl_s, from_s, nxt_e_s, beat_e_s;
    logic [MAXE-1:0]   act_in_s, src_act_s;
    logic              legal_in_s, found_s, hit_s, last_slice_s, cin_s;
    logic [5:0]        src_op_s;
    logic [2:0]        src_type_s;
    logic [1:0]        src_sew_s;
    logic [VLEN-1:0]   src_vs1_s, src_vs2_s;
    logic [63:0]       src_scalar_s, vs2_el_s, op1_el_s;
    logic [6:0]        sew_bits_s, n_sl_s;
    logic [3:0]        beat_s_s;
    logic [LANE_W:0]   slice_res_s;
    logic [9:0]        beat_off_s;

    assign vlmax_in_s = 8'(MAXE) >> vsew[1:0];
    assign legal_in_s = (vsew <= 3'd3) && ((11'd8 << vsew) <= 11'(ELEN)) &&
                        ((op_type == 3'b001) || (op_type == 3'b010) || (op_type == 3'b100)) &&
                        op_supported(opcode);
`ifdef RVV_ALU_MASK_EN
    assign act_in_s = vm ? {MAXE{1'b1}} : v0_mask[MAXE-1:0];
`else
    assign act_in_s = {MAXE{1'b1}};
`endif

    // Operand source: live inputs while idle (first beat is built at accept), latched copy afterwards.
    always_comb begin
        if (state_q == ST_IDLE) begin
            src_op_s     = opcode;
            src_type_s   = op_type;
            src_sew_s    = vsew[1:0];
            src_vs1_s    = vs1_in;
            src_vs2_s    = vs2_in;
            src_scalar_s = scalar;
            src_vl_s     = (vl < vlmax_in_s) ? vl : vlmax_in_s;
            src_act_s    = act_in_s;
        end else begin
            src_op_s     = op_q;
            src_type_s   = type_q;
            src_sew_s    = sew_q;
            src_vs1_s    = vs1_q;
            src_vs2_s    = vs2_q;
            src_scalar_s = scalar_q;
            src_vl_s     = vl_q;
            src_act_s    = act_q;
        end
    end

    // Next-beat selection (element/slice walk, masked-element skip) and slice datapath.
    always_comb begin
        from_s  = (state_q == ST_IDLE) ? 8'd0 : (elem_q + 8'd1);
        found_s = 1'b0;
        nxt_e_s = 8'd0;
        hit_s   = 1'b0;
        for (int i = MAXE - 1; i >= 0; i--) begin
            hit_s   = (8'(i) >= from_s) && (8'(i) < src_vl_s) && src_act_s[i];
            found_s = found_s | hit_s;
            nxt_e_s = hit_s ? 8'(i) : nxt_e_s;
        end
        sew_bits_s   = 7'd8 << src_sew_s;
        n_sl_s       = (sew_bits_s > 7'(LANE_W)) ? (sew_bits_s >> LW_LOG) : 7'd1;
        last_slice_s = (({3'd0, slice_q} + 7'd1) >= n_sl_s);
        if ((state_q == ST_IDLE) || last_slice_s) begin
            beat_e_s = nxt_e_s;
            beat_s_s = 4'd0;
        end else begin
            beat_e_s = elem_q;
            beat_s_s = slice_q + 4'd1;
        end
        cin_s    = (beat_s_s == 4'd0) ? is_sub(src_op_s) : carry_q;
        vs2_el_s = get_elem(src_vs2_s, beat_e_s, src_sew_s);
        case (src_type_s)
            3'b001:  op1_el_s = get_elem(src_vs1_s, beat_e_s, src_sew_s);
            3'b010:  op1_el_s = zext_sew(src_scalar_s, src_sew_s);
            3'b100:  op1_el_s = zext_sew({{59{src_scalar_s[4]}}, src_scalar_s[4:0]}, src_sew_s);
            default: op1_el_s = 64'd0;
        endcase
        slice_res_s = calc_slice(src_op_s, vs2_el_s, op1_el_s, src_sew_s, beat_s_s, cin_s);
        beat_off_s  = (10'(beat_e_s) << (3'd3 + {1'b0, src_sew_s})) + (10'(beat_s_s) << LW_LOG);
    end

    // Sequencer next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        wr_off_d   = wr_off_q;
        carry_d    = carry_q;
        elem_d     = elem_q;
        slice_d    = slice_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        op_d       = op_q;
        type_d     = type_q;
        sew_d      = sew_q;
        vl_d       = vl_q;
        vs1_d      = vs1_q;
        vs2_d      = vs2_q;
        scalar_d   = scalar_q;
        act_d      = act_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = opcode;
                    type_d   = op_type;
                    sew_d    = vsew[1:0];
                    vl_d     = src_vl_s;
                    vs1_d    = vs1_in;
                    vs2_d    = vs2_in;
                    scalar_d = scalar;
                    act_d    = act_in_s;
                    ready_d  = 1'b0;
                    if (!legal_in_s) begin
                        state_d   = ST_ERR;
                        illegal_d = 1'b1;
                    end else if (found_s) begin
                        state_d    = ST_RUN;
                        wr_valid_d = 1'b1;
                        wr_data_d  = slice_res_s[LANE_W-1:0];
                        wr_off_d   = beat_off_s;
                        carry_d    = slice_res_s[LANE_W];
                        elem_d     = beat_e_s;
                        slice_d    = beat_s_s;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (wr_valid_q && wr_ready) begin
                    if (!last_slice_s || found_s) begin
                        wr_data_d = slice_res_s[LANE_W-1:0];
                        wr_off_d  = beat_off_s;
                        carry_d   = slice_res_s[LANE_W];
                        elem_d    = beat_e_s;
                        slice_d   = beat_s_s;
                    end else begin
                        state_d    = ST_DONE;
                        wr_valid_d = 1'b0;
                        done_d     = 1'b1;
                        carry_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                elem_d  = 8'd0;
                slice_d = 4'd0;
            end
            default: begin
                state_d    = ST_IDLE;
                ready_d    = 1'b1;
                wr_valid_d = 1'b0;
            end
        endcase
    end

    // State, outputs and latched instruction registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_data_q  <= {LANE_W{1'b0}};
            wr_off_q   <= 10'd0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            carry_q    <= 1'b0;
            elem_q     <= 8'd0;
            slice_q    <= 4'd0;
            op_q       <= 6'd0;
            type_q     <= 3'd0;
            sew_q      <= 2'd0;
            vl_q       <= 8'd0;
            vs1_q      <= {VLEN{1'b0}};
            vs2_q      <= {VLEN{1'b0}};
            scalar_q   <= 64'd0;
            act_q      <= {MAXE{1'b0}};
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_off_q   <= wr_off_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            carry_q    <= carry_d;
            elem_q     <= elem_d;
            slice_q    <= slice_d;
            op_q       <= op_d;
            type_q     <= type_d;
            sew_q      <= sew_d;
            vl_q       <= vl_d;
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            scalar_q   <= scalar_d;
            act_q      <= act_d;
        end
    end

    assign ready    = ready_q;
    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_data_q;
    assign wr_off   = wr_off_q;
    assign done     = done_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_rvv_lane_alu_seq.sv
// Bench for rvv_lane_alu_seq: directed plan cases plus random instructions against a whole-element model.
module tb_rvv_lane_alu_seq;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start, start32;
    logic         ready, ready32;
    logic [5:0]   opcode;
    logic [2:0]   op_type, vsew;
    logic [7:0]   vl;
    logic [127:0] vs1_in, vs2_in;
    logic [63:0]  scalar;
    logic         wr_valid, wr_valid32, wr_ready;
    logic [31:0]  wr_data, wr_data32;
    logic [9:0]   wr_off, wr_off32;
    logic         done, done32, illegal, illegal32;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [31:0] d; logic [9:0] o; } beat_t;
    beat_t exp_q[$];
    logic [5:0] op_tab [0:12];

    always #5 clk = ~clk;

    rvv_lane_alu_seq #(.VLEN(128), .LANE_W(32), .ELEN(64)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .ready(ready), .opcode(opcode),
        .op_type(op_type), .vsew(vsew), .vl(vl), .vs1_in(vs1_in), .vs2_in(vs2_in),
        .scalar(scalar), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_off(wr_off), .done(done), .illegal(illegal));

    rvv_lane_alu_seq #(.VLEN(128), .LANE_W(32), .ELEN(32)) u_dut32 (
        .clk(clk), .resetn(resetn), .start(start32), .ready(ready32), .opcode(opcode),
        .op_type(op_type), .vsew(vsew), .vl(vl), .vs1_in(vs1_in), .vs2_in(vs2_in),
        .scalar(scalar), .wr_valid(wr_valid32), .wr_ready(wr_ready), .wr_data(wr_data32),
        .wr_off(wr_off32), .done(done32), .illegal(illegal32));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sew_mask(input int sew);
        return (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
    endfunction

    function automatic longint sx(input logic [63:0] x, input int sew);
        longint t;
        t = longint'(x << (64 - sew));
        return t >>> (64 - sew);
    endfunction

    function automatic logic [63:0] elem_of(input logic [127:0] v, input int e, input int sew);
        logic [127:0] t;
        t = v >> (e * sew);
        return t[63:0] & sew_mask(sew);
    endfunction

    // Reference: full SEW-bit element result in plain arithmetic, then cut into 32-bit slices.
    task automatic build_expect(input logic [5:0] op, input logic [2:0] ty, input logic [2:0] sw,
                                input logic [7:0] vlv, input logic [127:0] a1, input logic [127:0] a2,
                                input logic [63:0] sc);
        int sew, n, nsl, sh;
        logic [63:0] a, b, r, m;
        longint t;
        exp_q.delete();
        sew = 8 << sw;
        m   = sew_mask(sew);
        n   = (int'(vlv) < 128 / sew) ? int'(vlv) : 128 / sew;
        nsl = (sew > 32) ? sew / 32 : 1;
        for (int e = 0; e < n; e++) begin
            a = elem_of(a2, e, sew);
            case (ty)
                3'b001:  b = elem_of(a1, e, sew);
                3'b010:  b = sc & m;
                default: b = {{59{sc[4]}}, sc[4:0]} & m;
            endcase
            sh = int'(b & 64'(sew - 1));
            case (op)
                6'h00:   r = a + b;
                6'h02:   r = a - b;
                6'h03:   r = b - a;
                6'h04:   r = (a < b) ? a : b;
                6'h05:   r = (sx(a, sew) < sx(b, sew)) ? a : b;
                6'h06:   r = (a > b) ? a : b;
                6'h07:   r = (sx(a, sew) > sx(b, sew)) ? a : b;
                6'h09:   r = a & b;
                6'h0A:   r = a | b;
                6'h0B:   r = a ^ b;
                6'h25:   r = a << sh;
                6'h28:   r = a >> sh;
                6'h29:   begin t = sx(a, sew); r = t >>> sh; end
                default: r = 64'd0;
            endcase
            r = r & m;
            for (int s = 0; s < nsl; s++) begin
                exp_q.push_back('{d: 32'(r >> (s * 32)), o: 10'(e * sew + s * 32)});
            end
        end
    endtask

    // bp_mode: 0 always ready, 1 random backpressure, 2 stall beat 1 for three cycles.
    task automatic run_instr(input logic [5:0] op, input logic [2:0] ty, input logic [2:0] sw,
                             input logic [7:0] vlv, input logic [127:0] a1, input logic [127:0] a2,
                             input logic [63:0] sc, input int bp_mode, input bit exp_ill);
        int c, npop, last_pop, stall, nb;
        bit hold, fin;
        logic [31:0] pd;
        logic [9:0] po;
        beat_t bt;
        exp_q.delete();
        if (!exp_ill) build_expect(op, ty, sw, vlv, a1, a2, sc);
        nb = exp_q.size();
        opcode = op; op_type = ty; vsew = sw; vl = vlv;
        vs1_in = a1; vs2_in = a2; scalar = sc; wr_ready = 1'b1; start = 1'b1;
        check("ready_before_start", ready, 1);
        @(negedge clk);
        start  = 1'b0;
        vs1_in = {$urandom, $urandom, $urandom, $urandom};
        vs2_in = {$urandom, $urandom, $urandom, $urandom};
        scalar = {$urandom, $urandom};
        opcode = 6'($urandom); vl = 8'($urandom); vsew = 3'($urandom_range(0, 3));
        if (exp_ill) begin
            check("illegal_pulse", illegal, 1);
            check("illegal_no_valid", wr_valid, 0);
            check("illegal_ready_low", ready, 0);
            check("illegal_no_done", done, 0);
            @(negedge clk);
            check("illegal_ready_back", ready, 1);
            check("illegal_one_cycle", illegal, 0);
            return;
        end
        c = 1; npop = 0; last_pop = 0; hold = 0; stall = 0; fin = 0; pd = 32'd0; po = 10'd0;
        while (!fin && c < 400) begin
            if (hold && wr_valid) begin
                check("hold_data", wr_data, pd);
                check("hold_off", wr_off, po);
            end
            if (done) begin
                fin = 1;
                check("done_beat_count", npop, nb);
                check("done_timing", c, last_pop + 1);
                check("done_no_valid", wr_valid, 0);
            end else begin
                if (c == 1) check("busy_ready_low", ready, 0);
                start = (bp_mode == 2) && (c == 2);
                case (bp_mode)
                    1:       wr_ready = ($urandom_range(0, 3) != 0);
                    2:       begin
                        if (npop == 1 && stall < 3) begin wr_ready = 1'b0; stall++; end
                        else wr_ready = 1'b1;
                    end
                    default: wr_ready = 1'b1;
                endcase
                if (wr_valid && wr_ready) begin
                    if (npop >= nb) begin
                        check("beat_count", npop + 1, nb);
                    end else begin
                        bt = exp_q.pop_front();
                        check("beat_data", wr_data, bt.d);
                        check("beat_off", wr_off, bt.o);
                    end
                    npop++;
                    last_pop = c;
                    hold = 0;
                end else begin
                    hold = wr_valid; pd = wr_data; po = wr_off;
                end
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        wr_ready = 1'b1;
        if (!fin) check("done_timeout", c, 0);
        if (bp_mode == 0 && nb > 0) check("back_to_back", last_pop, nb);
        if (fin) begin
            @(negedge clk);
            check("ready_after_done", ready, 1);
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r1, r2;
        int k;
        op_tab = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                   6'h09, 6'h0A, 6'h0B, 6'h25, 6'h28, 6'h29};
        resetn = 1'b0; start = 1'b0; start32 = 1'b0; wr_ready = 1'b1;
        opcode = 6'd0; op_type = 3'b001; vsew = 3'd0; vl = 8'd0;
        vs1_in = 128'd0; vs2_in = 128'd0; scalar = 64'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_off", wr_off, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        resetn = 1'b1;
        @(negedge clk);

        // carry across two 32-bit slices of a 64-bit element
        run_instr(6'h00, 3'b001, 3'd3, 8'd2,
                  {64'd1, 64'd1}, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF}, 64'd0, 0, 0);
        // VX vsub with vl clamped to VLMAX
        run_instr(6'h02, 3'b010, 3'd0, 8'd200, 128'd0, {16{8'h03}}, 64'h05, 0, 0);
        // signed min and VI arithmetic shift right
        run_instr(6'h05, 3'b001, 3'd2, 8'd1, 128'd1, 128'hFFFF_FFFF, 64'd0, 0, 0);
        run_instr(6'h29, 3'b100, 3'd2, 8'd1, 128'd0, 128'h8000_0000, 64'd4, 0, 0);
        // directed backpressure stall with an ignored start during the run
        run_instr(6'h00, 3'b001, 3'd2, 8'd4, {4{$urandom}}, {4{$urandom}}, 64'd0, 2, 0);
        // illegal encodings and empty vector
        run_instr(6'h00, 3'b001, 3'd4, 8'd4, 128'd0, 128'd0, 64'd0, 0, 1);
        run_instr(6'h00, 3'b011, 3'd2, 8'd4, 128'd0, 128'd0, 64'd0, 0, 1);
        run_instr(6'h01, 3'b001, 3'd2, 8'd4, 128'd0, 128'd0, 64'd0, 0, 1);
        run_instr(6'h0B, 3'b001, 3'd1, 8'd0, {4{$urandom}}, {4{$urandom}}, 64'd0, 0, 0);

        // SEW above ELEN on the ELEN=32 instance
        opcode = 6'h00; op_type = 3'b001; vsew = 3'd3; vl = 8'd2;
        check("e32_ready_before", ready32, 1);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        check("e32_illegal_pulse", illegal32, 1);
        check("e32_no_valid", wr_valid32, 0);
        check("e32_ready_low", ready32, 0);
        @(negedge clk);
        check("e32_ready_back", ready32, 1);
        check("e32_illegal_cleared", illegal32, 0);
        check("e32_no_done", done32, 0);

        // asynchronous reset during beat 2 of 4
        opcode = 6'h00; op_type = 3'b001; vsew = 3'd2; vl = 8'd4;
        vs1_in = {4{$urandom}}; vs2_in = {4{$urandom}}; wr_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_beat2_off", wr_off, 10'd64);
        #2 resetn = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_wr_valid", wr_valid, 0);
        check("abort_wr_data", wr_data, 0);
        check("abort_wr_off", wr_off, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("abort_still_idle", wr_valid, 0);
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, 32'hFFFF_FFFF, $urandom, 32'hFFFF_FFFF};
        run_instr(6'h00, 3'b001, 3'd3, 8'd2, r1, r2, 64'd0, 0, 0);

        // random legal instructions with random backpressure
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 2);
            run_instr(op_tab[$urandom_range(0, 12)], 3'(1 << k), 3'($urandom_range(0, 3)),
                      8'($urandom_range(0, 40)),
                      {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom}, int'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
